hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller_pkg.sv | 17 +
 rtl/hazard_controller_sat_counter.sv | 30 +++
 rtl/hazard_controller.sv | 141 ++++++++++++++
 tb/tb_hazard_controller.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_controller_pkg.sv
// Shared pipeline definitions: controller state encoding, NOP encoding and default widths.
package hazard_controller_pkg;

    localparam int unsigned REG_ADDR_W_DEFAULT  = 5;
    localparam int unsigned CNT_W_DEFAULT       = 16;
    localparam int unsigned MEM_TIMEOUT_DEFAULT = 64;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StFault   = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hazard_controller_sat_counter.sv
// Saturating up-counter: increments when inc is high, holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: memory-stall FSM with timeout fault, redirect flush,
// load-use interlock and saturating stall/flush performance counters.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int unsigned REG_ADDR_W  = REG_ADDR_W_DEFAULT,
    parameter int unsigned CNT_W       = CNT_W_DEFAULT,
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_redirect,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  id_ex_stall,
    output logic                  ex_mem_stall,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  mem_wb_bubble,
    output logic                  fault,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_events
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    hz_state_e   state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [WAIT_W-1:0] wait_inc;
    logic        load_hit;
    logic        mem_stall;
    logic        pipe_free;
    logic        redirect_act;

    assign wait_inc = wait_q + 1'b1;
    assign load_hit = ex_mem_read && (ex_rd != '0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        mem_stall     = 1'b0;
        pipe_free     = 1'b0;
        redirect_act  = 1'b0;
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        id_ex_stall   = 1'b0;
        ex_mem_stall  = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        fault         = 1'b0;

        unique case (state_q)
            StRun: begin
                if (mem_req && !mem_ready) begin
                    mem_stall = 1'b1;
                    wait_d    = '0;
                    state_d   = StMemWait;
                end else begin
                    pipe_free = 1'b1;
                end
            end
            StMemWait: begin
                if (!mem_ready) begin
                    mem_stall = 1'b1;
                    wait_d    = wait_inc;
                    if (wait_inc == WAIT_W'(MEM_TIMEOUT)) begin
                        state_d = StFault;
                    end
                end else begin
                    pipe_free = 1'b1;
                    state_d   = StRun;
                end
            end
            StFault: begin
                pc_stall      = 1'b1;
                if_id_flush   = 1'b1;
                id_ex_flush   = 1'b1;
                mem_wb_bubble = 1'b1;
                fault         = 1'b1;
            end
            default: state_d = StRun;
        endcase

        // Redirect waits for the memory stall to clear: EX is frozen so it stays asserted.
        if (mem_stall) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_stall  = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (pipe_free && ex_redirect) begin
            redirect_act = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
        end else if (pipe_free && load_hit) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StRun;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (pc_stall),
        .count(stall_cycles)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_flush_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (redirect_act),
        .count(flush_events)
    );

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller (CNT_W=4, MEM_TIMEOUT=4).
module tb_hazard_controller;

    localparam int unsigned AW = 5;
    localparam int unsigned CW = 4;

    localparam logic [7:0] IDLE     = 8'b0000_0000;
    localparam logic [7:0] LOADUSE  = 8'b1100_0100;
    localparam logic [7:0] REDIR    = 8'b0000_1100;
    localparam logic [7:0] MEMSTALL = 8'b1111_0010;
    localparam logic [7:0] FAULTP   = 8'b1000_1111;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] id_rs1, id_rs2, ex_rd;
    logic          id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect, mem_req, mem_ready;
    logic          pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic          if_id_flush, id_ex_flush, mem_wb_bubble, fault;
    logic [CW-1:0] stall_cycles, flush_events;
    logic [7:0]    ctl;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    hazard_controller #(
        .REG_ADDR_W (AW),
        .CNT_W      (CW),
        .MEM_TIMEOUT(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .ex_rd        (ex_rd),
        .ex_mem_read  (ex_mem_read),
        .ex_redirect  (ex_redirect),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .pc_stall     (pc_stall),
        .if_id_stall  (if_id_stall),
        .id_ex_stall  (id_ex_stall),
        .ex_mem_stall (ex_mem_stall),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .mem_wb_bubble(mem_wb_bubble),
        .fault        (fault),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    assign ctl = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                  if_id_flush, id_ex_flush, mem_wb_bubble, fault};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_redirect = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // Reset asserted between edges so the checks only pass if it acts asynchronously.
    task automatic do_reset(input string tag);
        @(negedge clk);
        idle();
        reset = 1'b1;
        #1;
        chk({tag, "_ctl"}, 32'(ctl), 32'(IDLE));
        chk({tag, "_stall_cnt"}, 32'(stall_cycles), 32'd0);
        chk({tag, "_flush_cnt"}, 32'(flush_events), 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        #1;
        chk("por_ctl", 32'(ctl), 32'(IDLE));
        chk("por_stall_cnt", 32'(stall_cycles), 32'd0);
        chk("por_flush_cnt", 32'(flush_events), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // No hazard
        @(negedge clk); idle(); #1;
        chk("idle_ctl", 32'(ctl), 32'(IDLE));

        // Load-use on rs2
        @(negedge clk);
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1; #1;
        chk("loaduse_rs2", 32'(ctl), 32'(LOADUSE));
        @(negedge clk); idle(); #1;
        chk("loaduse_clear", 32'(ctl), 32'(IDLE));
        chk("loaduse_stall_cnt", 32'(stall_cycles), 32'd1);

        // Matching rs1 but not used: no stall
        @(negedge clk);
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b0; #1;
        chk("unused_rs1", 32'(ctl), 32'(IDLE));

        // Load to x0 never stalls
        @(negedge clk);
        idle(); ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1; #1;
        chk("rd_zero", 32'(ctl), 32'(IDLE));
        @(negedge clk); idle(); #1;
        chk("rd_zero_stall_cnt", 32'(stall_cycles), 32'd1);

        // Redirect beats load-use
        @(negedge clk);
        ex_redirect = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
        #1;
        chk("redir_over_lu", 32'(ctl), 32'(REDIR));
        @(negedge clk); idle(); #1;
        chk("redir_flush_cnt", 32'(flush_events), 32'd1);
        chk("redir_stall_cnt", 32'(stall_cycles), 32'd1);

        // Memory stall: ready low 3 cycles, then high
        do_reset("rst1");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); mem_req = 1'b1; mem_ready = 1'b0; #1;
            chk($sformatf("memstall_%0d", i), 32'(ctl), 32'(MEMSTALL));
        end
        @(negedge clk); mem_ready = 1'b1; #1;
        chk("mem_release", 32'(ctl), 32'(IDLE));
        // Back in RUN: with mem_req low, ready low must not stall
        @(negedge clk); idle(); #1;
        chk("mem_back_run", 32'(ctl), 32'(IDLE));
        chk("mem_stall_cnt", 32'(stall_cycles), 32'd3);

        // Redirect held during a memory stall acts only on the ready cycle
        @(negedge clk); mem_req = 1'b1; ex_redirect = 1'b1; #1;
        chk("redir_in_memstall", 32'(ctl), 32'(MEMSTALL));
        @(negedge clk); mem_ready = 1'b1; #1;
        chk("redir_after_mem", 32'(ctl), 32'(REDIR));
        @(negedge clk); idle(); #1;
        chk("redir_after_mem_cnt", 32'(flush_events), 32'd1);

        // Async reset mid-MEM_WAIT
        @(negedge clk); mem_req = 1'b1; mem_ready = 1'b0;
        @(negedge clk); #1;
        chk("mw_before_rst", 32'(ctl), 32'(MEMSTALL));
        do_reset("rst_mw");
        @(negedge clk); #1;
        chk("mw_after_rst", 32'(ctl), 32'(IDLE));

        // Timeout to FAULT, then stall counter saturation
        do_reset("rst2");
        @(negedge clk); mem_req = 1'b1; mem_ready = 1'b0; #1;
        chk("to_entry", 32'(ctl), 32'(MEMSTALL));
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk); #1;
            chk($sformatf("to_wait_%0d", i), 32'(ctl), 32'(MEMSTALL));
        end
        @(negedge clk); #1;
        chk("to_fault", 32'(ctl), 32'(FAULTP));
        chk("to_fault_cnt", 32'(stall_cycles), 32'd5);
        mem_ready = 1'b1; mem_req = 1'b0;
        for (int i = 0; i < 15; i++) @(negedge clk);
        #1;
        chk("fault_sticky", 32'(ctl), 32'(FAULTP));
        chk("sat_hold", 32'(stall_cycles), 32'd15);
        @(negedge clk); #1;
        chk("sat_hold2", 32'(stall_cycles), 32'd15);
        chk("fault_no_flush_cnt", 32'(flush_events), 32'd0);
        do_reset("rst_fault");
        @(negedge clk); #1;
        chk("fault_cleared", 32'(ctl), 32'(IDLE));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
